// File: rtl/rom_stream_fifo_pkg.sv
// Shared definitions for the ROM prefetch streamer: FSM state codes and default sizing.
// The DMA engine imports this package too.
package rom_stream_fifo_pkg;

  localparam int unsigned DefaultDepth = 8;
  localparam int unsigned DefaultAw    = 23;

  typedef logic [2:0] state_t;

  localparam state_t StIdle   = 3'd0;
  localparam state_t StIssue  = 3'd1;
  localparam state_t StWait   = 3'd2;
  localparam state_t StFlush  = 3'd3;
  localparam state_t StFinish = 3'd4;

endpackage

// File: rtl/rom_stream_fifo_sync_fifo.sv
// Single-clock FIFO with a show-ahead head, synchronous flush and occupancy count.
// Depth must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/rom_stream_fifo.sv
// Prefetching ROM read streamer: one outstanding ROM read at a time, words buffered for the DMA.
// Optional ROM_STREAM_CHECKSUM_EN adds a 16-bit wrapping sum of all popped words.
module rom_stream_fifo
  import rom_stream_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned AW    = DefaultAw
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [AW-1:0] base_addr_i,
  input  logic [15:0]   word_count_i,
  output logic [AW-1:0] rom_addr_o,
  output logic          rom_load_o,
  input  logic [15:0]   rom_data_i,
  input  logic          rom_ready_i,
  output logic [15:0]   out_data_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o
`ifdef ROM_STREAM_CHECKSUM_EN
  ,
  output logic [15:0]   checksum_o
`endif
);

  state_t          state_q, state_d;
  logic [AW-1:0]   next_addr_q, next_addr_d;
  logic [15:0]     remaining_q, remaining_d;
  logic            done_q, done_d;
  logic            fifo_flush, fifo_push, fifo_full, fifo_empty, pop, slot_free;
  logic [$clog2(DEPTH):0] fifo_count;

  assign out_valid_o = !fifo_empty;
  assign pop         = out_valid_o && out_ready_i;
  assign slot_free   = !fifo_full || pop;
  assign rom_addr_o  = next_addr_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != StIdle) || done_q;

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    rom_load_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          fifo_flush  = 1'b1;
          next_addr_d = base_addr_i;
          remaining_d = word_count_i;
          state_d     = (word_count_i == 16'd0) ? StFinish : StIssue;
        end
      end
      StIssue: begin
        if (abort_i) begin
          fifo_flush = 1'b1;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (slot_free) begin
          rom_load_o = 1'b1;
          state_d    = StWait;
        end
      end
      StWait: begin
        // An abort coinciding with the returning read has nothing left to wait for.
        if (rom_ready_i && abort_i) begin
          fifo_flush = 1'b1;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (rom_ready_i) begin
          fifo_push   = 1'b1;
          next_addr_d = next_addr_q + AW'(1);
          remaining_d = remaining_q - 16'd1;
          state_d     = (remaining_q == 16'd1) ? StFinish : StIssue;
        end else if (abort_i) begin
          fifo_flush = 1'b1;
          state_d    = StFlush;
        end
      end
      StFlush: begin
        fifo_flush = 1'b1;
        if (rom_ready_i) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StFinish: begin
        if (abort_i) begin
          fifo_flush = 1'b1;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (fifo_count == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      next_addr_q <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      done_q      <= done_d;
    end
  end

  sync_fifo #(
    .Depth (DEPTH),
    .Width (16)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (fifo_flush),
    .push_i  (fifo_push),
    .data_i  (rom_data_i),
    .pop_i   (pop),
    .data_o  (out_data_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef ROM_STREAM_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (state_q == StIdle && start_i) checksum_d = '0;
    else if (pop)                     checksum_d = checksum_q + out_data_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) checksum_q <= '0;
    else       checksum_q <= checksum_d;
  end

  assign checksum_o = checksum_q;
`endif

endmodule
